// File: rtl/intra_pred_plane_pe.sv
// Plane-mode 4x4 prediction engine: one predicted row per enabled cycle from seed/b/c gradients.
// Optional block checksum output is enabled by defining INTRA_PLANE_CHECKSUM_EN.
module intra_pred_plane_pe #(
    parameter int PIX_W = 8,
    parameter int ACC_W = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [4:0]         blk4x4_counter,
    input  logic [14:0]        seed,
    input  logic [11:0]        b,
    input  logic [11:0]        c,
    output logic               busy,
    output logic               row_valid,
    output logic [1:0]         row_idx,
    output logic [4*PIX_W-1:0] pred_row,
    output logic               done,
    output logic [4:0]         blk_idx_out,
`ifdef INTRA_PLANE_CHECKSUM_EN
    output logic [11:0]        blk_checksum,
`endif
    output logic [14:0]        PE0_sum_reg,
    output logic [14:0]        PE3_sum_reg
);

    typedef enum logic {IDLE, ROW} state_t;

    localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(16);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    function automatic logic [PIX_W-1:0] clipPix(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = (v + ROUND) >>> 5;
        if (s < 0)
            clipPix = '0;
        else if (s > PIX_MAX)
            clipPix = '1;
        else
            clipPix = s[PIX_W-1:0];
    endfunction

    state_t                   state_q, state_d;
    logic [1:0]               r_q, r_d;
    logic signed [ACC_W-1:0]  lane_q [4];
    logic signed [ACC_W-1:0]  lane_d [4];
    logic signed [ACC_W-1:0]  loadLane [4];
    logic signed [ACC_W-1:0]  emitLane [4];
    logic signed [ACC_W-1:0]  cStep_q, cStep_d;
    logic signed [ACC_W-1:0]  seedExt, bExt, cExt;
    logic [4:0]               blk_q, blk_d;
    logic                     rowValid_q, rowValid_d;
    logic                     done_q, done_d;
    logic [1:0]               rowIdx_q, rowIdx_d;
    logic [4*PIX_W-1:0]       predRow_q, predRow_d, emitRow;
    logic [14:0]              pe0_q, pe0_d, pe3_q, pe3_d;
    logic [11:0]              emitSum;
    logic                     lastRow, accept;
`ifdef INTRA_PLANE_CHECKSUM_EN
    logic [11:0]              csAcc_q, csAcc_d, cs_q, cs_d;
`endif

    // Lane seeds for a new block; 3b is formed as (b<<1)+b.
    always_comb begin
        seedExt     = ACC_W'(signed'(seed));
        bExt        = ACC_W'(signed'(b));
        cExt        = ACC_W'(signed'(c));
        loadLane[0] = seedExt;
        loadLane[1] = seedExt + bExt;
        loadLane[2] = seedExt + (bExt <<< 1);
        loadLane[3] = seedExt + (bExt <<< 1) + bExt;
    end

    assign lastRow = (state_q == ROW) && (r_q == 2'd3);
    assign accept  = ena && start && ((state_q == IDLE) || lastRow);

    // The row being registered comes from the fresh seeds on accept, otherwise from the running lanes.
    always_comb begin
        emitRow = '0;
        emitSum = '0;
        for (int x = 0; x < 4; x++) begin
            emitLane[x] = accept ? loadLane[x] : lane_q[x];
            emitRow[x*PIX_W +: PIX_W] = clipPix(emitLane[x]);
            emitSum = emitSum + 12'(clipPix(emitLane[x]));
        end
    end

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        cStep_d    = cStep_q;
        blk_d      = blk_q;
        rowValid_d = rowValid_q;
        done_d     = done_q;
        rowIdx_d   = rowIdx_q;
        predRow_d  = predRow_q;
        pe0_d      = pe0_q;
        pe3_d      = pe3_q;
        for (int x = 0; x < 4; x++) lane_d[x] = lane_q[x];
`ifdef INTRA_PLANE_CHECKSUM_EN
        csAcc_d    = csAcc_q;
        cs_d       = cs_q;
`endif
        if (accept) begin
            state_d    = ROW;
            r_d        = 2'd0;
            cStep_d    = cExt;
            blk_d      = blk4x4_counter;
            rowValid_d = 1'b1;
            done_d     = 1'b0;
            rowIdx_d   = 2'd0;
            predRow_d  = emitRow;
            pe0_d      = loadLane[3][14:0];
            for (int x = 0; x < 4; x++) lane_d[x] = loadLane[x] + cExt;
`ifdef INTRA_PLANE_CHECKSUM_EN
            csAcc_d    = emitSum;
`endif
        end else if (ena && (state_q == ROW)) begin
            if (lastRow) begin
                state_d    = IDLE;
                rowValid_d = 1'b0;
                done_d     = 1'b0;
                rowIdx_d   = 2'd0;
            end else begin
                r_d       = r_q + 2'd1;
                rowIdx_d  = r_q + 2'd1;
                predRow_d = emitRow;
                for (int x = 0; x < 4; x++) lane_d[x] = lane_q[x] + cStep_q;
`ifdef INTRA_PLANE_CHECKSUM_EN
                csAcc_d   = csAcc_q + emitSum;
`endif
                if (r_q == 2'd2) begin
                    done_d = 1'b1;
                    pe3_d  = lane_q[0][14:0];
`ifdef INTRA_PLANE_CHECKSUM_EN
                    cs_d   = csAcc_q + emitSum;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            cStep_q    <= '0;
            blk_q      <= '0;
            rowValid_q <= 1'b0;
            done_q     <= 1'b0;
            rowIdx_q   <= '0;
            predRow_q  <= '0;
            pe0_q      <= '0;
            pe3_q      <= '0;
            for (int x = 0; x < 4; x++) lane_q[x] <= '0;
`ifdef INTRA_PLANE_CHECKSUM_EN
            csAcc_q    <= '0;
            cs_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            cStep_q    <= cStep_d;
            blk_q      <= blk_d;
            rowValid_q <= rowValid_d;
            done_q     <= done_d;
            rowIdx_q   <= rowIdx_d;
            predRow_q  <= predRow_d;
            pe0_q      <= pe0_d;
            pe3_q      <= pe3_d;
            for (int x = 0; x < 4; x++) lane_q[x] <= lane_d[x];
`ifdef INTRA_PLANE_CHECKSUM_EN
            csAcc_q    <= csAcc_d;
            cs_q       <= cs_d;
`endif
        end
    end

    assign busy        = (state_q == ROW);
    assign row_valid   = rowValid_q;
    assign row_idx     = rowIdx_q;
    assign pred_row    = predRow_q;
    assign done        = done_q;
    assign blk_idx_out = blk_q;
    assign PE0_sum_reg = pe0_q;
    assign PE3_sum_reg = pe3_q;
`ifdef INTRA_PLANE_CHECKSUM_EN
    assign blk_checksum = cs_q;
`endif

endmodule

// File: tb/tb_intra_pred_plane_pe.sv
// Self-checking bench for intra_pred_plane_pe: directed plan cases plus random blocks
// against a per-pixel plane-formula reference model.
module tb_intra_pred_plane_pe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  blk = '0;
    logic [14:0] seed = '0;
    logic [11:0] b = '0;
    logic [11:0] c = '0;
    logic        busy, row_valid, done;
    logic [1:0]  row_idx;
    logic [31:0] pred_row;
    logic [4:0]  blk_idx_out;
    logic [14:0] PE0_sum_reg, PE3_sum_reg;
`ifdef INTRA_PLANE_CHECKSUM_EN
    logic [11:0] blk_checksum;
`endif

    intra_pred_plane_pe dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .blk4x4_counter(blk), .seed(seed), .b(b), .c(c),
        .busy(busy), .row_valid(row_valid), .row_idx(row_idx), .pred_row(pred_row),
        .done(done), .blk_idx_out(blk_idx_out),
`ifdef INTRA_PLANE_CHECKSUM_EN
        .blk_checksum(blk_checksum),
`endif
        .PE0_sum_reg(PE0_sum_reg), .PE3_sum_reg(PE3_sum_reg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int expPix [4][4];
    int expPe0, expPe3, expCs;
    logic [4:0] expBlk;

    function automatic int clipPix(input int v);
        int t;
        t = (v + 16) >>> 5;
        if (t < 0) return 0;
        if (t > 255) return 255;
        return t;
    endfunction

    function automatic logic [31:0] expRow(input int y);
        logic [31:0] r;
        for (int x = 0; x < 4; x++) r[8*x +: 8] = 8'(expPix[y][x]);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives a start request and records the expected block from the plane formula.
    task automatic applyStimulus(input logic [14:0] s, input logic [11:0] bb, input logic [11:0] cc,
                                 input logic [4:0] k);
        int si, bi, ci;
        si = int'($signed(s));
        bi = int'($signed(bb));
        ci = int'($signed(cc));
        start = 1'b1; seed = s; b = bb; c = cc; blk = k;
        expCs = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                expPix[y][x] = clipPix(si + x*bi + y*ci);
                expCs += expPix[y][x];
            end
        expPe0 = (si + 3*bi) & 32'h7FFF;
        expPe3 = (si + 3*ci) & 32'h7FFF;
        expBlk = k;
    endtask

    task automatic checkRow(input int y);
        checkOutput($sformatf("row%0d_valid", y), 32'(row_valid), 32'd1);
        checkOutput($sformatf("row%0d_idx", y), 32'(row_idx), 32'(y));
        checkOutput($sformatf("row%0d_data", y), pred_row, expRow(y));
        checkOutput($sformatf("row%0d_done", y), 32'(done), 32'(y == 3));
        checkOutput($sformatf("row%0d_busy", y), 32'(busy), 32'd1);
        checkOutput($sformatf("row%0d_blk", y), 32'(blk_idx_out), 32'(expBlk));
        if (y == 0) checkOutput("pe0_sum", 32'(PE0_sum_reg), 32'(expPe0));
        if (y == 3) begin
            checkOutput("pe3_sum", 32'(PE3_sum_reg), 32'(expPe3));
`ifdef INTRA_PLANE_CHECKSUM_EN
            checkOutput("checksum", 32'(blk_checksum), 32'(expCs));
`endif
        end
    endtask

    task automatic checkIdle();
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_valid", 32'(row_valid), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_valid"}, 32'(row_valid), 32'd0);
        checkOutput({tag, "_idx"}, 32'(row_idx), 32'd0);
        checkOutput({tag, "_data"}, pred_row, 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_blk"}, 32'(blk_idx_out), 32'd0);
        checkOutput({tag, "_pe0"}, 32'(PE0_sum_reg), 32'd0);
        checkOutput({tag, "_pe3"}, 32'(PE3_sum_reg), 32'd0);
`ifdef INTRA_PLANE_CHECKSUM_EN
        checkOutput({tag, "_cs"}, 32'(blk_checksum), 32'd0);
`endif
    endtask

    // chained=1 means we are already at the negedge of the previous done cycle.
    task automatic runBlock(input logic [14:0] s, input logic [11:0] bb, input logic [11:0] cc,
                            input logic [4:0] k, input bit chained);
        if (!chained) @(negedge clk);
        applyStimulus(s, bb, cc, k);
        for (int y = 0; y < 4; y++) begin
            @(negedge clk);
            start = 1'b0;
            checkRow(y);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
        @(negedge clk);
        checkIdle();

        $display("[TB] flat / ramps / clip");
        runBlock(15'd4096, 12'd0, 12'd0, 5'd3, 1'b0);
        runBlock(15'd4096, 12'd32, 12'd0, 5'd7, 1'b1);
        runBlock(15'd4096, 12'd0, 12'd32, 5'd16, 1'b1);
        @(negedge clk); checkIdle();
        runBlock(15'd8160, 12'd100, 12'd100, 5'd23, 1'b0);
        runBlock(15'h7F38, 12'd0, 12'd0, 5'd1, 1'b1);
        @(negedge clk); checkIdle();

        $display("[TB] ignored start and stall");
        @(negedge clk);
        applyStimulus(15'd3000, 12'd45, 12'hFE0, 5'd9);
        @(negedge clk); start = 1'b0; checkRow(0);
        start = 1'b1; seed = 15'h1234; b = 12'h7FF; c = 12'h7FF; blk = 5'd30;
        @(negedge clk); start = 1'b0; checkRow(1);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkRow(1);
        end
        ena = 1'b1;
        @(negedge clk); checkRow(2);
        @(negedge clk); checkRow(3);
        @(negedge clk); checkIdle();

        $display("[TB] reset mid-block");
        @(negedge clk);
        applyStimulus(15'd5000, 12'd20, 12'd20, 5'd12);
        @(negedge clk); start = 1'b0; checkRow(0);
        @(negedge clk); checkRow(1);
        @(negedge clk); checkRow(2);
        rst_n = 1'b0;
        #1 checkAllZero("midreset");
        @(negedge clk);
        checkAllZero("midreset_hold");
        rst_n = 1'b1;
        runBlock(15'd2500, 12'hFF0, 12'd7, 5'd5, 1'b0);
        @(negedge clk); checkIdle();

        $display("[TB] random blocks");
        for (int i = 0; i < 16; i++) begin
            bit ch;
            ch = (i > 0) && ($urandom_range(0, 1) == 1);
            if (i > 0 && !ch) begin
                @(negedge clk);
                checkIdle();
            end
            runBlock(15'($urandom), 12'($urandom), 12'($urandom), 5'($urandom_range(0, 23)), ch);
        end
        @(negedge clk); checkIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
